// File: rtl/sata_defs_pkg.sv
// Shared SATA link-layer primitive encodings, dword type flags and tx mux state type.
package sata_defs_pkg;

    localparam logic [31:0] ALIGN_PRIM = 32'h7B4A_4ABC;
    localparam logic [31:0] HOLD_PRIM  = 32'hD5D5_AA7C;
    localparam logic [31:0] SYNC_PRIM  = 32'hB5B5_957C;

    localparam logic DWORD_IS_PRIM = 1'b1;
    localparam logic DWORD_IS_DATA = 1'b0;

    typedef enum logic {
        S_ALIGN = 1'b0,
        S_PASS  = 1'b1
    } tx_mux_state_t;

endpackage

// File: rtl/sata_align_timer.sv
// ALIGN period timer: modulo-ALIGN_PERIOD counter advanced only on accepted output dwords.
// Zero latency: align_slot reflects the current count; a stalled enable freezes the count.
module sata_align_timer #(
    parameter int ALIGN_PERIOD = 256,
    parameter int ALIGN_BURST  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic align_slot
);

    localparam int CW = (ALIGN_PERIOD > 2) ? $clog2(ALIGN_PERIOD) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(ALIGN_PERIOD - 1);
    localparam logic [CW-1:0] CNT_BURST = CW'(ALIGN_BURST);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign align_slot = (cnt < CNT_BURST);

endmodule

// File: rtl/sata_link_tx_mux.sv
// Link tx scheduler: periodic ALIGN burst, frame data or requested primitive (ALIGN only with SATA_TX_ALIGN_INSERT_EN).
// One cycle latency from selection to registered o_data; everything holds while o_ready=0, d_ready only on accepted data.
module sata_link_tx_mux
    import sata_defs_pkg::*;
#(
    parameter int ALIGN_PERIOD = 256,
    parameter int ALIGN_BURST  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] prim_code,
    input  logic        data_sel,
    input  logic [31:0] d_data,
    input  logic        d_valid,
    output logic        d_ready,
    output logic [31:0] o_data,
    output logic        o_datak,
    input  logic        o_ready,
    output logic        align_active
);

    if (ALIGN_BURST < 1 || ALIGN_PERIOD <= ALIGN_BURST) begin : g_param_check
        $error("sata_link_tx_mux: need 1 <= ALIGN_BURST < ALIGN_PERIOD");
    end

    tx_mux_state_t state;
    logic [31:0]   nxt_data;
    logic          nxt_datak;
    logic          nxt_align;

`ifdef SATA_TX_ALIGN_INSERT_EN
    logic align_slot;

    sata_align_timer #(
        .ALIGN_PERIOD (ALIGN_PERIOD),
        .ALIGN_BURST  (ALIGN_BURST)
    ) u_align_timer (
        .clk        (clk),
        .reset      (reset),
        .en         (o_ready),
        .align_slot (align_slot)
    );

    // The period counter is the state: the burst window is exactly cnt < ALIGN_BURST.
    assign state = align_slot ? S_ALIGN : S_PASS;
`else
    assign state = S_PASS;
`endif

    always_comb begin
        nxt_data  = prim_code;
        nxt_datak = DWORD_IS_PRIM;
        nxt_align = 1'b0;
        d_ready   = 1'b0;
        unique case (state)
            S_ALIGN: begin
                nxt_data  = ALIGN_PRIM;
                nxt_align = 1'b1;
            end
            S_PASS: begin
                if (data_sel && d_valid) begin
                    nxt_data  = d_data;
                    nxt_datak = DWORD_IS_DATA;
                    d_ready   = o_ready && !reset;
                end else if (data_sel) begin
                    nxt_data  = HOLD_PRIM;
                end
            end
            default: begin
                nxt_data = SYNC_PRIM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_data       <= SYNC_PRIM;
            o_datak      <= DWORD_IS_PRIM;
            align_active <= 1'b0;
        end else if (o_ready) begin
            o_data       <= nxt_data;
            o_datak      <= nxt_datak;
            align_active <= nxt_align;
        end
    end

endmodule

// File: tb/tb_sata_link_tx_mux.sv
// Directed bench for sata_link_tx_mux; expectations follow the ALIGN build when SATA_TX_ALIGN_INSERT_EN is defined.
module tb_sata_link_tx_mux;

    localparam logic [31:0] ALIGN = 32'h7B4A_4ABC;
    localparam logic [31:0] HOLD  = 32'hD5D5_AA7C;
    localparam logic [31:0] SYNC  = 32'hB5B5_957C;
    localparam logic [31:0] X_RDY = 32'h5757_B57C;
    localparam int PERIOD = 256;
    localparam int BURST  = 2;
`ifdef SATA_TX_ALIGN_INSERT_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] prim_code;
    logic        data_sel;
    logic [31:0] d_data;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] o_data;
    logic        o_datak;
    logic        o_ready;
    logic        align_active;

    int n_tests = 0;
    int n_fail  = 0;
    int acc     = 0;
    logic [31:0] next_d = 32'd1;
    logic [31:0] last_d = SYNC;
    logic        last_k = 1'b1;
    logic        last_a = 1'b0;
    logic        took;

    always #5 clk = ~clk;

    sata_link_tx_mux #(.ALIGN_PERIOD(PERIOD), .ALIGN_BURST(BURST)) dut (
        .clk          (clk),
        .reset        (reset),
        .prim_code    (prim_code),
        .data_sel     (data_sel),
        .d_data       (d_data),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .o_data       (o_data),
        .o_datak      (o_datak),
        .o_ready      (o_ready),
        .align_active (align_active)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (accepted=%0d)", tag, got, exp, acc);
        end
    endtask

    // One clock: expected next dword from the scheduling rules, d_ready before the edge, outputs after.
    task automatic step();
        logic [31:0] ed;
        logic        ek, ea, er, adv, slot;
        #1;
        adv  = o_ready;
        slot = ALIGN_ON && ((acc % PERIOD) < BURST);
        er   = 1'b0;
        if (!adv) begin
            ed = last_d; ek = last_k; ea = last_a;
        end else if (slot) begin
            ed = ALIGN; ek = 1'b1; ea = 1'b1;
        end else if (data_sel && d_valid) begin
            ed = d_data; ek = 1'b0; ea = 1'b0; er = 1'b1;
        end else if (data_sel) begin
            ed = HOLD; ek = 1'b1; ea = 1'b0;
        end else begin
            ed = prim_code; ek = 1'b1; ea = 1'b0;
        end
        check("d_ready", {31'd0, d_ready}, {31'd0, er});
        took = er;
        @(posedge clk);
        #1;
        check("o_data", o_data, ed);
        check("o_datak", {31'd0, o_datak}, {31'd0, ek});
        check("align_active", {31'd0, align_active}, {31'd0, ea});
        last_d = ed; last_k = ek; last_a = ea;
        if (adv) acc++;
        if (took) next_d++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_o_data"}, o_data, SYNC);
        check({tag, "_o_datak"}, {31'd0, o_datak}, 32'd1);
        check({tag, "_d_ready"}, {31'd0, d_ready}, 32'd0);
        check({tag, "_align_active"}, {31'd0, align_active}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; o_ready = 1'b1; data_sel = 1'b0; d_valid = 1'b0;
        d_data = '0; prim_code = X_RDY;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");

        // Primitive stream: ALIGN pairs every PERIOD dwords, X_RDY elsewhere.
        reset = 1'b0; acc = 0;
        for (int i = 0; i < 4 * PERIOD; i++) step();

        // Continuous frame data.
        data_sel = 1'b1; d_valid = 1'b1;
        for (int i = 0; i < 600; i++) begin
            d_data = next_d;
            step();
        end

        // d_valid toggles every 3 cycles: HOLD fills the gaps.
        for (int i = 0; i < 300; i++) begin
            d_valid = ((i / 3) % 2) == 1;
            d_data  = next_d;
            step();
        end

        // Stall between the two ALIGNs of a burst.
        data_sel = 1'b0; d_valid = 1'b0; prim_code = X_RDY;
        for (int i = 0; i < PERIOD && (acc % PERIOD) != 0; i++) step();
        step();
        data_sel = 1'b1; d_valid = 1'b1; d_data = next_d;
        o_ready = 1'b0;
        for (int i = 0; i < 10; i++) step();
        o_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d_data = next_d;
            step();
        end

        // Reset in the middle of a burst; a full burst follows release.
        data_sel = 1'b0; d_valid = 1'b0;
        for (int i = 0; i < PERIOD && (acc % PERIOD) != 0; i++) step();
        step();
        reset = 1'b1;
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; acc = 0;
        last_d = SYNC; last_k = 1'b1; last_a = 1'b0;

        prim_code = SYNC;
        for (int i = 0; i < 1000; i++) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
